// File: rtl/demorgan_pkg.sv
// Shared types and constants for the De Morgan gate self-test checker.
package demorgan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } state_e;

  // Response bus bit positions, MSB..LSB.
  localparam int unsigned BitNA      = 7;
  localparam int unsigned BitNB      = 6;
  localparam int unsigned BitAorB    = 5;
  localparam int unsigned BitAandB   = 4;
  localparam int unsigned BitNAandB  = 3;
  localparam int unsigned BitNAornB  = 2;
  localparam int unsigned BitNAorB   = 1;
  localparam int unsigned BitNAandnB = 0;

  localparam logic [7:0] EXP_00 = 8'hCF;
  localparam logic [7:0] EXP_01 = 8'hAC;
  localparam logic [7:0] EXP_10 = 8'h6C;
  localparam logic [7:0] EXP_11 = 8'h30;

endpackage

// File: rtl/demorgan_expect.sv
// Golden response of a correct De Morgan gate block for a given {A,B}.
module demorgan_expect
  import demorgan_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  output logic [7:0] exp_o
);

  always_comb begin
    exp_o = EXP_00;
    unique case ({a_i, b_i})
      2'b00: exp_o = EXP_00;
      2'b01: exp_o = EXP_01;
      2'b10: exp_o = EXP_10;
      2'b11: exp_o = EXP_11;
    endcase
  end

endmodule

// File: rtl/demorgan_checker.sv
// Built-in self-test for the De Morgan gate block: sweeps the 2-input truth table,
// compares the eight responses and keeps a saturating error count plus first-failure info.
module demorgan_checker
  import demorgan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 A,
  output logic                 B,
  input  logic                 nA,
  input  logic                 nB,
  input  logic                 AorB,
  input  logic                 AandB,
  input  logic                 nAandB,
  input  logic                 nAornB,
  input  logic                 nAorB,
  input  logic                 nAandnB,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           fail_vec,
  output logic [7:0]           fail_mask
);

  localparam int unsigned CntW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CntW-1:0]      SettleLoad = CntW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [PassW-1:0]     LastPass   = PassW'(PASSES - 1);
  localparam logic [ERR_CNT_W-1:0] ErrMax     = '1;

  state_e               state_q;
  logic [1:0]           idx_q;
  logic [PassW-1:0]     pass_cnt_q;
  logic [CntW-1:0]      settle_q;
  logic                 a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [1:0]           fvec_q;
  logic [7:0]           fmask_q;

  logic [7:0] resp, expected, mism;
  logic       last_vec;

  demorgan_expect u_expect (
    .a_i  (a_q),
    .b_i  (b_q),
    .exp_o(expected)
  );

  always_comb begin
    resp             = '0;
    resp[BitNA]      = nA;
    resp[BitNB]      = nB;
    resp[BitAorB]    = AorB;
    resp[BitAandB]   = AandB;
    resp[BitNAandB]  = nAandB;
    resp[BitNAornB]  = nAornB;
    resp[BitNAorB]   = nAorB;
    resp[BitNAandnB] = nAandnB;
  end

  assign mism     = resp ^ expected;
  assign err_d    = ((mism != 8'h00) && (err_q != ErrMax)) ? err_q + 1'b1 : err_q;
  assign last_vec = (idx_q == 2'd3) && (pass_cnt_q == LastPass);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      settle_q   <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fvec_q     <= '0;
      fmask_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StDrive;
            idx_q      <= '0;
            pass_cnt_q <= '0;
            {a_q, b_q} <= 2'b00;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fvec_q     <= '0;
            fmask_q    <= '0;
          end
        end
        StDrive: begin
          if (SETTLE_CYCLES == 0) begin
            state_q <= StCheck;
          end else begin
            state_q  <= StSettle;
            settle_q <= SettleLoad;
          end
        end
        StSettle: begin
          if (settle_q == '0) state_q <= StCheck;
          else                settle_q <= settle_q - 1'b1;
        end
        StCheck: begin
          err_q <= err_d;
          // A zero count means no earlier mismatch in this run.
          if ((mism != 8'h00) && (err_q == '0)) begin
            fvec_q  <= idx_q;
            fmask_q <= mism;
          end
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) pass_cnt_q <= pass_cnt_q + 1'b1;
          if (last_vec) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            state_q    <= StDrive;
            {a_q, b_q} <= idx_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fvec_q;
  assign fail_mask = fmask_q;

endmodule
